// File: rtl/bit_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bit_packer_pkg
//  Purpose  : Shared constants, FSM state type and code-length mask helper
//             for the JPEG entropy-coded output bit packer.
//  Contents : WORD_W, MAX_CODE_LEN, LEN_W, ACC_W, packer_state_t, len_mask()
//  Revision : 1.0  initial release
// ============================================================================
package bit_packer_pkg;

    localparam int WORD_W       = 16;
    localparam int MAX_CODE_LEN = 16;
    localparam int LEN_W        = $clog2(MAX_CODE_LEN + 1);
    localparam int ACC_W        = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } packer_state_t;

    // Right-aligned mask with the low 'l' bits set; l == MAX_CODE_LEN gives
    // all ones, which is why the intermediate is one bit wider.
    function automatic logic [MAX_CODE_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
        logic [MAX_CODE_LEN:0] one;
        logic [MAX_CODE_LEN:0] m;
        one = {{MAX_CODE_LEN{1'b0}}, 1'b1};
        m   = (one << l) - one;
        return m[MAX_CODE_LEN-1:0];
    endfunction

endpackage : bit_packer_pkg
`default_nettype wire

// File: rtl/bit_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : bit_packer_if
//  Purpose  : Groups the code-input handshake (from the Huffman coder) and
//             the word-output handshake (to byte_stuffer) of bit_packer.
//  Ports    : ena_in/rdy_out/code/len  upstream code transfer
//             flush/done                upstream end-of-scan handshake
//             ena_out/rdy_in/out        packed word to byte_stuffer
//             flush_out/done_in         end-of-scan handshake to byte_stuffer
//  Modports : slave  - the packer itself
//             master - the surrounding environment
//  Revision : 1.0  initial release
// ============================================================================
interface bit_packer_if
    import bit_packer_pkg::*;
#(
    parameter int MAX_LEN = MAX_CODE_LEN
) ();

    localparam int LW = $clog2(MAX_LEN + 1);

    logic                ena_in;
    logic                rdy_out;
    logic [MAX_LEN-1:0]  code;
    logic [LW-1:0]       len;
    logic                flush;
    logic                done;
    logic                ena_out;
    logic                rdy_in;
    logic [WORD_W-1:0]   out;
    logic                flush_out;
    logic                done_in;

    modport slave (
        input  ena_in, code, len, flush, rdy_in, done_in,
        output rdy_out, done, ena_out, out, flush_out
    );

    modport master (
        output ena_in, code, len, flush, rdy_in, done_in,
        input  rdy_out, done, ena_out, out, flush_out
    );

endinterface : bit_packer_if
`default_nettype wire

// File: rtl/bit_packer.sv
`default_nettype none
// ============================================================================
//  Module   : bit_packer
//  Purpose  : Packs variable-length, right-aligned MSB-first codes into
//             16-bit words for byte_stuffer. On flush the final partial word
//             is padded with 1-bits, flush is forwarded downstream and done
//             is reported upstream once byte_stuffer signals its own done.
//  Ports    : clk        clock
//             rst        asynchronous active-high reset
//             bus        bit_packer_if.slave (code in, word out, flush/done)
//             word_cnt   [BIT_PACKER_CNT_EN only] words transferred
//             bit_cnt    [BIT_PACKER_CNT_EN only] sum of accepted lengths
//  Options  : define BIT_PACKER_CNT_EN to add the saturating statistics
//             counters word_cnt and bit_cnt.
//  Revision : 1.0  initial release
// ============================================================================
module bit_packer
    import bit_packer_pkg::*;
#(
    // The 32-bit accumulator relies on fill_after_emit (<=15) + len (<=16)
    // staying within 31 bits, so this is not meant to exceed 16.
    parameter int MAX_LEN = MAX_CODE_LEN
) (
    input  wire logic    clk,
    input  wire logic    rst,
    bit_packer_if.slave  bus
`ifdef BIT_PACKER_CNT_EN
    ,
    output logic [31:0]  word_cnt,
    output logic [31:0]  bit_cnt
`endif
);

    localparam int            FILL_W = LEN_W;
    localparam logic [FILL_W-1:0] FULL = FILL_W'(WORD_W);

    packer_state_t       r_state;
    packer_state_t       w_state_nxt;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic [FILL_W-1:0]   r_fill;
    logic [FILL_W-1:0]   w_fill_nxt;

    logic                w_emit;
    logic                w_accept;
    logic [ACC_W-1:0]    w_acc_e;
    logic [FILL_W-1:0]   w_fill_e;
    logic [5:0]          w_shamt;
    logic [ACC_W-1:0]    w_place;
    logic [MAX_LEN-1:0]  w_masked;

    assign w_masked = bus.code & len_mask(bus.len);

    // ------------------------------------------------------------------
    // Next-state, datapath merge and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_fill_nxt    = r_fill;
        w_emit        = 1'b0;
        w_accept      = 1'b0;
        w_acc_e       = r_acc;
        w_fill_e      = r_fill;
        w_shamt       = 6'd0;
        w_place       = '0;
        bus.rdy_out   = 1'b0;
        bus.ena_out   = 1'b0;
        bus.out       = r_acc[ACC_W-1 -: WORD_W];
        bus.flush_out = 1'b0;
        bus.done      = 1'b0;

        unique case (r_state)
            RUN: begin
                w_emit      = (r_fill >= FULL) && bus.rdy_in;
                bus.ena_out = w_emit;
                if (w_emit) begin
                    w_acc_e  = {r_acc[ACC_W-WORD_W-1:0], {WORD_W{1'b0}}};
                    w_fill_e = r_fill - FULL;
                end
                // Accepting in the emit cycle is what gives one code per
                // cycle; reset forces ready low while it is held.
                bus.rdy_out = ((r_fill < FULL) || w_emit) && !bus.flush && !rst;
                w_accept    = bus.ena_in && bus.rdy_out;

                // Left-justify the code just below the bits already held:
                // its MSB lands at bit (31 - fill_after_emit).
                w_shamt = 6'd32 - {1'b0, bus.len} - {1'b0, w_fill_e};
                w_place = {{(ACC_W-MAX_LEN){1'b0}}, w_masked} << w_shamt;

                if (w_accept) begin
                    w_acc_nxt  = w_acc_e | w_place;
                    w_fill_nxt = w_fill_e + bus.len;
                end else begin
                    w_acc_nxt  = w_acc_e;
                    w_fill_nxt = w_fill_e;
                end

                // Full words still pending are drained before padding.
                if (bus.flush && (r_fill < FULL)) begin
                    w_state_nxt = PAD;
                end
            end

            PAD: begin
                bus.out = r_acc[ACC_W-1 -: WORD_W] | ({WORD_W{1'b1}} >> r_fill);
                if (r_fill == '0) begin
                    w_state_nxt = DRAIN;
                end else begin
                    bus.ena_out = bus.rdy_in;
                    if (bus.rdy_in) begin
                        w_acc_nxt   = '0;
                        w_fill_nxt  = '0;
                        w_state_nxt = DRAIN;
                    end
                end
            end

            DRAIN: begin
                bus.flush_out = 1'b1;
                if (bus.done_in) begin
                    w_state_nxt = DONE;
                end
            end

            DONE: begin
                // byte_stuffer keeps seeing flush until the next reset.
                bus.flush_out = 1'b1;
                bus.done      = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, accumulator and fill registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_acc   <= '0;
            r_fill  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

`ifdef BIT_PACKER_CNT_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    logic [32:0] w_bit_sum;
    assign w_bit_sum = {1'b0, bit_cnt} + {{(33-LEN_W){1'b0}}, bus.len};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (bus.ena_out && (word_cnt != '1)) begin
                word_cnt <= word_cnt + 32'd1;
            end
            if (w_accept) begin
                bit_cnt <= w_bit_sum[32] ? '1 : w_bit_sum[31:0];
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // Codes longer than the port allows are a protocol error upstream.
    a_len_legal : assert property (
        @(posedge clk) disable iff (rst)
        (bus.ena_in && bus.rdy_out) |-> (int'(bus.len) <= MAX_LEN)
    );
`endif

endmodule : bit_packer
`default_nettype wire

// File: tb/tb_bit_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_packer
//  Purpose  : Directed self-checking bench for bit_packer: reset state,
//             basic packing, throughput, masking/straddle, flush padding,
//             asynchronous reset and backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bit_packer;
    import bit_packer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_vec;
    int   n_err;

    always #5 clk = ~clk;

    bit_packer_if #(.MAX_LEN(16)) bus ();

`ifdef BIT_PACKER_CNT_EN
    logic [31:0] word_cnt;
    logic [31:0] bit_cnt;
`endif

    bit_packer #(.MAX_LEN(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef BIT_PACKER_CNT_EN
        ,
        .word_cnt (word_cnt),
        .bit_cnt  (bit_cnt)
`endif
    );

    // Apply a code at the falling edge and settle before checking.
    task automatic drive(input logic e, input logic [15:0] c, input logic [4:0] l);
        @(negedge clk);
        bus.ena_in = e;
        bus.code   = c;
        bus.len    = l;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        bus.ena_in  = 1'b0;
        bus.code    = '0;
        bus.len     = '0;
        bus.flush   = 1'b0;
        bus.rdy_in  = 1'b1;
        bus.done_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.ena_in  = 1'b0;
        bus.code    = '0;
        bus.len     = '0;
        bus.flush   = 1'b0;
        bus.rdy_in  = 1'b1;
        bus.done_in = 1'b0;
        #1;
        n_vec++; if (bus.rdy_out !== 1'b0) begin n_err++; $display("FAIL reset_rdy_out: got %b want 0", bus.rdy_out); end
        n_vec++; if (bus.ena_out !== 1'b0) begin n_err++; $display("FAIL reset_ena_out: got %b want 0", bus.ena_out); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_vec++; if (bus.flush_out !== 1'b0) begin n_err++; $display("FAIL reset_flush_out: got %b want 0", bus.flush_out); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++; if (bus.rdy_out !== 1'b1) begin n_err++; $display("FAIL post_reset_rdy_out: got %b want 1", bus.rdy_out); end
    endtask

    task automatic test_basic_pack();
        do_reset();
        drive(1'b1, 16'h000A, 5'd4);
        n_vec++; if (bus.ena_out !== 1'b0) begin n_err++; $display("FAIL basic_no_word_1: ena_out %b want 0", bus.ena_out); end
        drive(1'b1, 16'h0BCD, 5'd12);
        n_vec++; if (bus.rdy_out !== 1'b1) begin n_err++; $display("FAIL basic_rdy_2: rdy_out %b want 1", bus.rdy_out); end
        drive(1'b0, 16'h0000, 5'd0);
        n_vec++; if (bus.ena_out !== 1'b1) begin n_err++; $display("FAIL basic_ena: ena_out %b want 1", bus.ena_out); end
        n_vec++; if (bus.out !== 16'hABCD) begin n_err++; $display("FAIL basic_word: out %h want abcd", bus.out); end
        n_vec++; if (bus.rdy_out !== 1'b1) begin n_err++; $display("FAIL basic_rdy_3: rdy_out %b want 1", bus.rdy_out); end
        drive(1'b0, 16'h0000, 5'd0);
        n_vec++; if (bus.ena_out !== 1'b0) begin n_err++; $display("FAIL basic_empty: ena_out %b want 0", bus.ena_out); end
    endtask

    task automatic test_throughput();
        logic [15:0] exp_w;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'(16'h1111 * (i + 1)), 5'd16);
            n_vec++; if (bus.rdy_out !== 1'b1) begin n_err++; $display("FAIL thr_rdy[%0d]: rdy_out %b want 1", i, bus.rdy_out); end
            if (i == 0) begin
                n_vec++; if (bus.ena_out !== 1'b0) begin n_err++; $display("FAIL thr_first: ena_out %b want 0", bus.ena_out); end
            end else begin
                exp_w = 16'(16'h1111 * i);
                n_vec++; if (bus.ena_out !== 1'b1 || bus.out !== exp_w) begin
                    n_err++; $display("FAIL thr_word[%0d]: ena %b out %h want ena 1 out %h", i, bus.ena_out, bus.out, exp_w);
                end
            end
        end
        drive(1'b0, 16'h0000, 5'd0);
        n_vec++; if (bus.ena_out !== 1'b1 || bus.out !== 16'h5555) begin
            n_err++; $display("FAIL thr_last: ena %b out %h want ena 1 out 5555", bus.ena_out, bus.out);
        end
`ifdef BIT_PACKER_CNT_EN
        n_vec++; if (bit_cnt !== 32'd80) begin n_err++; $display("FAIL thr_bit_cnt: %0d want 80", bit_cnt); end
        n_vec++; if (word_cnt !== 32'd4) begin n_err++; $display("FAIL thr_word_cnt: %0d want 4", word_cnt); end
`endif
    endtask

    task automatic test_masking();
        do_reset();
        drive(1'b1, 16'hFFFF, 5'd3);
        drive(1'b1, 16'h0000, 5'd15);
        n_vec++; if (bus.ena_out !== 1'b0) begin n_err++; $display("FAIL mask_early: ena_out %b want 0", bus.ena_out); end
        drive(1'b1, 16'h0003, 5'd14);
        n_vec++; if (bus.ena_out !== 1'b1 || bus.out !== 16'hE000) begin
            n_err++; $display("FAIL mask_word1: ena %b out %h want ena 1 out e000", bus.ena_out, bus.out);
        end
        drive(1'b0, 16'h0000, 5'd0);
        n_vec++; if (bus.ena_out !== 1'b1 || bus.out !== 16'h0003) begin
            n_err++; $display("FAIL mask_word2: ena %b out %h want ena 1 out 0003", bus.ena_out, bus.out);
        end
    endtask

    task automatic test_flush_pad();
        do_reset();
        drive(1'b1, 16'h0005, 5'd3);
        @(negedge clk);
        bus.ena_in = 1'b0;
        bus.flush  = 1'b1;
        #1;
        n_vec++; if (bus.rdy_out !== 1'b0) begin n_err++; $display("FAIL flush_rdy: rdy_out %b want 0", bus.rdy_out); end
        @(negedge clk); #1;
        n_vec++; if (bus.ena_out !== 1'b1 || bus.out !== 16'hBFFF) begin
            n_err++; $display("FAIL pad_word: ena %b out %h want ena 1 out bfff", bus.ena_out, bus.out);
        end
        n_vec++; if (bus.flush_out !== 1'b0) begin n_err++; $display("FAIL pad_flush_out: %b want 0", bus.flush_out); end
        @(negedge clk); #1;
        n_vec++; if (bus.flush_out !== 1'b1 || bus.ena_out !== 1'b0 || bus.done !== 1'b0) begin
            n_err++; $display("FAIL drain: flush_out %b ena %b done %b want 1 0 0", bus.flush_out, bus.ena_out, bus.done);
        end
        bus.done_in = 1'b1;
        @(negedge clk);
        bus.done_in = 1'b0;
        #1;
        n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL done_rise: done %b want 1", bus.done); end
        bus.flush  = 1'b0;
        bus.ena_in = 1'b1;
        bus.len    = 5'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_vec++; if (bus.done !== 1'b1 || bus.rdy_out !== 1'b0 || bus.flush_out !== 1'b1) begin
                n_err++; $display("FAIL done_sticky[%0d]: done %b rdy %b flush_out %b want 1 0 1", i, bus.done, bus.rdy_out, bus.flush_out);
            end
        end
        bus.ena_in = 1'b0;
    endtask

    // Entered straight from the DONE state left by test_flush_pad.
    task automatic test_async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (bus.done !== 1'b0 || bus.flush_out !== 1'b0 || bus.rdy_out !== 1'b0) begin
            n_err++; $display("FAIL arst_done: done %b flush_out %b rdy %b want 0 0 0", bus.done, bus.flush_out, bus.rdy_out);
        end
        @(negedge clk);
        rst         = 1'b0;
        bus.rdy_in  = 1'b0;
        bus.done_in = 1'b0;
        bus.flush   = 1'b0;
        drive(1'b1, 16'h000A, 5'd4);
        drive(1'b1, 16'hBCDE, 5'd16);
        @(negedge clk);
        bus.ena_in = 1'b0;
        bus.rdy_in = 1'b1;
        #1;
        n_vec++; if (bus.ena_out !== 1'b1) begin n_err++; $display("FAIL arst_pre: ena_out %b want 1", bus.ena_out); end
        #1 rst = 1'b1;
        #1;
        n_vec++; if (bus.ena_out !== 1'b0 || bus.rdy_out !== 1'b0) begin
            n_err++; $display("FAIL arst_mid: ena %b rdy %b want 0 0", bus.ena_out, bus.rdy_out);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 16'h1234, 5'd16);
        drive(1'b0, 16'h0000, 5'd0);
        n_vec++; if (bus.ena_out !== 1'b1 || bus.out !== 16'h1234) begin
            n_err++; $display("FAIL arst_resume: ena %b out %h want ena 1 out 1234", bus.ena_out, bus.out);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.rdy_in = 1'b0;
        drive(1'b1, 16'h000A, 5'd4);
        drive(1'b1, 16'hBCDE, 5'd16);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 16'h0000, 5'd0);
            n_vec++; if (bus.ena_out !== 1'b0 || bus.rdy_out !== 1'b0 || bus.out !== 16'hABCD) begin
                n_err++; $display("FAIL bp_hold[%0d]: ena %b rdy %b out %h want 0 0 abcd", i, bus.ena_out, bus.rdy_out, bus.out);
            end
        end
        @(negedge clk);
        bus.rdy_in = 1'b1;
        bus.ena_in = 1'b1;
        bus.code   = 16'h0005;
        bus.len    = 5'd4;
        #1;
        n_vec++; if (bus.ena_out !== 1'b1 || bus.out !== 16'hABCD || bus.rdy_out !== 1'b1) begin
            n_err++; $display("FAIL bp_release: ena %b out %h rdy %b want 1 abcd 1", bus.ena_out, bus.out, bus.rdy_out);
        end
        @(negedge clk);
        bus.ena_in = 1'b0;
        bus.flush  = 1'b1;
        #1;
        n_vec++; if (bus.ena_out !== 1'b0) begin n_err++; $display("FAIL bp_idle: ena_out %b want 0", bus.ena_out); end
        @(negedge clk); #1;
        n_vec++; if (bus.ena_out !== 1'b1 || bus.out !== 16'hE5FF) begin
            n_err++; $display("FAIL bp_pad: ena %b out %h want ena 1 out e5ff", bus.ena_out, bus.out);
        end
        bus.flush = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic_pack();
        test_throughput();
        test_masking();
        test_flush_pad();
        test_async_reset();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bit_packer
`default_nettype wire
